sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width passed to the attached sp_ram.
REQ-002 Parameter NUM_PORTS, default 2, number of requesters; legal range 2..8.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_i  input  NUM_PORTS  per-requester access request.
REQ-006 Port addr_i  input  NUM_PORTS x ADDR_WIDTH  per-requester word address.
REQ-007 Port we_i  input  NUM_PORTS  per-requester write enable.
REQ-008 Port be_i  input  NUM_PORTS x 4  per-requester byte enables.
REQ-009 Port wdata_i  input  NUM_PORTS x 32  per-requester write data.
REQ-010 Port gnt_o  output  NUM_PORTS  one-hot grant; the access is accepted this cycle.
REQ-011 Port rvalid_o  output  NUM_PORTS  one-hot response strobe, one cycle after the grant.
REQ-012 Port rdata_o  output  32  read data broadcast to all requesters; meaningful only with rvalid_o.
REQ-013 Ports ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o  output  1/ADDR_WIDTH/1/4/32  drive the sp_ram en_i/addr_i/we_i/be_i/wdata_i.
REQ-014 Port ram_rdata_i  input  32  sp_ram rdata_o.

Function
REQ-015 Grant SHALL be combinational: gnt_o[k] is asserted in the same cycle as req_i[k] when port k wins arbitration.
REQ-016 At most one gnt_o bit SHALL be set per cycle; gnt_o is zero when req_i is zero.
REQ-017 Arbitration SHALL be round-robin: the winner is the first requesting port at or after the priority pointer, searching upward with wrap from NUM_PORTS-1 to 0.
REQ-018 After a grant to port k, the pointer SHALL become (k+1) mod NUM_PORTS; the pointer holds in cycles with no grant.
REQ-019 ram_en_o SHALL equal the OR of req_i; the ram_* address, write-enable, byte-enable and write-data outputs SHALL be muxed from the winning port.
REQ-020 ram_we_o SHALL be 0 when no port is granted.
REQ-021 rvalid_o[k] SHALL be asserted exactly one cycle after gnt_o[k], for reads and writes alike.
REQ-022 rdata_o SHALL pass ram_rdata_i through combinationally.
REQ-023 A requester holds req_i and its payload stable until granted; after a grant it may drop req_i or issue back-to-back.
REQ-024 Back-to-back grants to alternating ports SHALL sustain one access per cycle with no bubble.
REQ-025 With a single port requesting continuously, that port SHALL be granted every cycle.

Reset
REQ-026 On rst, gnt_o and rvalid_o SHALL be 0 immediately, and the pointer SHALL be 0; the response register is cleared asynchronously.
REQ-027 An access granted in the cycle in which rst asserts SHALL produce no rvalid_o.

Configuration
REQ-028 Macro SP_RAM_ARB_STATS_EN, when defined, SHALL add:
- input stats_clr_i (1 bit);
- output stall_cnt_o (NUM_PORTS x 32).
REQ-029 stall_cnt_o[k] SHALL increment in each cycle in which req_i[k] is 1 and gnt_o[k] is 0.
REQ-030 stall_cnt_o[k] SHALL saturate at 0xFFFFFFFF.
REQ-031 stall_cnt_o SHALL clear on rst or on stats_clr_i; when stats_clr_i coincides with a stall, clear wins.
REQ-032 Without SP_RAM_ARB_STATS_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-033 Package sp_ram_arb_pkg SHALL hold:
- MAX_PORTS = 8;
- the port-index typedef;
- the stall-counter width constant (32).
REQ-034 Winner selection SHALL live in sub-module sp_ram_rr_pick:
- inputs: request vector, pointer;
- outputs: one-hot winner, winner index;
- purely combinational.
REQ-035 The pointer, the response register and the counters SHALL stay in sp_ram_arbiter.

Verification
REQ-036 Contention: req_i=2'b11 held for 4 cycles from reset -> gnt_o sequence 01,10,01,10; rvalid_o follows one cycle later.
REQ-037 Data path: port1 writes 0xDEADBEEF with be=4'b0101 to addr 5, then port0 reads addr 5 -> rdata_o=0x00AD00EF with rvalid_o=2'b01, given memory preset to 0.
REQ-038 Solo port: port0 requests alone for 3 cycles -> gnt_o[0] set every cycle; pointer=1 afterward.
REQ-039 Reset mid-operation: rst asserted in the cycle of a grant -> rvalid_o stays 0 and the next grant after release follows pointer=0.
REQ-040 Stats (SP_RAM_ARB_STATS_EN defined): 2 ports contend for 6 cycles -> stall_cnt_o = 3 per port; stats_clr_i pulsed -> both counters 0 the next cycle.

Source files
------------

// File: rtl/sp_ram_arb_pkg.sv
// ============================================================================
// sp_ram_arb_pkg : shared constants and types for the sp_ram arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package sp_ram_arb_pkg;
    localparam int MAX_PORTS   = 8;
    localparam int STALL_CNT_W = 32;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
endpackage

`default_nettype wire

// File: rtl/sp_ram_rr_pick.sv
// ============================================================================
// sp_ram_rr_pick : combinational round-robin winner selection
// Revision 1.0
// ============================================================================
`default_nettype none

module sp_ram_rr_pick
    import sp_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output port_idx_t            idx
);

    logic [NUM_PORTS-1:0] w_masked;
    logic [NUM_PORTS-1:0] w_cand;
    logic                 w_found;

    // Requests at or above the pointer win first; otherwise wrap to the lowest requester.
    always_comb begin
        w_masked = '0;
        w_cand   = '0;
        w_found  = 1'b0;
        gnt      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_masked[i] = req[i] && (i >= int'(ptr));
        end
        w_cand = (|w_masked) ? w_masked : req;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_cand[i] && !w_found) begin
                w_found = 1'b1;
                gnt[i]  = 1'b1;
                idx     = port_idx_t'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
// ============================================================================
// sp_ram_arbiter : round-robin N-port arbiter in front of a single-port RAM.
// Optional stall counters enabled by macro SP_RAM_ARB_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_PORTS  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS-1:0][3:0]            be_i,
    input  logic [NUM_PORTS-1:0][31:0]           wdata_i,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    output logic [NUM_PORTS-1:0]                 rvalid_o,
    output logic [31:0]                          rdata_o,
    output logic                                 ram_en_o,
    output logic [ADDR_WIDTH-1:0]                ram_addr_o,
    output logic                                 ram_we_o,
    output logic [3:0]                           ram_be_o,
    output logic [31:0]                          ram_wdata_o,
    input  logic [31:0]                          ram_rdata_i
`ifdef SP_RAM_ARB_STATS_EN
    ,
    input  logic                                 stats_clr_i,
    output logic [NUM_PORTS-1:0][STALL_CNT_W-1:0] stall_cnt_o
`endif
);

    port_idx_t            r_ptr;
    logic [NUM_PORTS-1:0] r_rvalid;
    logic [NUM_PORTS-1:0] w_pick_gnt;
    port_idx_t            w_win_idx;

    sp_ram_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req (req_i),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_win_idx)
    );

    // Grants are masked while reset is high so they drop without waiting for a clock.
    assign gnt_o    = w_pick_gnt & {NUM_PORTS{~rst}};
    assign rvalid_o = r_rvalid;
    assign rdata_o  = ram_rdata_i;
    assign ram_en_o = |req_i;

    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_o[k]) begin
                ram_addr_o  = addr_i[k];
                ram_we_o    = we_i[k];
                ram_be_o    = be_i[k];
                ram_wdata_o = wdata_i[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= gnt_o;
            if (|gnt_o) begin
                r_ptr <= (w_win_idx == port_idx_t'(NUM_PORTS - 1)) ? '0
                                                                    : w_win_idx + port_idx_t'(1);
            end
        end
    end

`ifdef SP_RAM_ARB_STATS_EN
    logic [NUM_PORTS-1:0][STALL_CNT_W-1:0] r_stall_cnt;

    // Clear takes priority over a coincident stall; counts saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stats_clr_i) begin
            r_stall_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (req_i[k] && !gnt_o[k] && (r_stall_cnt[k] != '1)) begin
                    r_stall_cnt[k] <= r_stall_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
// ============================================================================
// tb_sp_ram_arbiter : scoreboard bench for sp_ram_arbiter with a behavioural sp_ram
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sp_ram_arbiter;
    localparam int N  = 2;
    localparam int AW = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0]          we;
    logic [N-1:0][3:0]     be;
    logic [N-1:0][31:0]    wdata;
    logic [N-1:0]          gnt;
    logic [N-1:0]          rvalid;
    logic [31:0]           rdata;
    logic                  ram_en;
    logic [AW-1:0]         ram_addr;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata = '0;
`ifdef SP_RAM_ARB_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [N-1:0][31:0]    stall_cnt;
    int unsigned           m_stall [N];
`endif

    always #5 clk = ~clk;

    sp_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .NUM_PORTS  (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
`ifdef SP_RAM_ARB_STATS_EN
        ,
        .stats_clr_i (stats_clr),
        .stall_cnt_o (stall_cnt)
`endif
    );

    // Behavioural single-port RAM, registered read, preset to zero.
    logic [31:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [N-1:0] onehot;
        bit           is_read;
        logic [31:0]  data;
    } resp_t;

    resp_t       sb [$];
    logic [31:0] exp_mem [0:(1<<AW)-1];
    int          m_ptr;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rr_model(input logic [N-1:0] r, input int p);
        logic [N-1:0] oh;
        oh = '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (p + i) % N;
            if (r[k]) begin
                oh[k] = 1'b1;
                return oh;
            end
        end
        return oh;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) if (b[i]) res[8*i +: 8] = nw[8*i +: 8];
        return res;
    endfunction

    // One clock: entered at posedge+1 with inputs applied, leaves at next posedge+1.
    task automatic step();
        logic [N-1:0] eg;
        resp_t        r;
        int           w;
        #3;
        eg = rr_model(req, m_ptr);
        w  = -1;
        for (int k = 0; k < N; k++) if (eg[k]) w = k;
        check_eq("gnt", gnt, eg);
        check_eq("ram_we", ram_we, (w >= 0) ? we[w] : 1'b0);
        check_eq("ram_en", ram_en, |req);
        if (w >= 0) check_eq("ram_addr", ram_addr, addr[w]);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check_eq("rvalid", rvalid, r.onehot);
            if (r.is_read) check_eq("rdata", rdata, r.data);
        end else begin
            check_eq("rvalid_idle", rvalid, '0);
        end
`ifdef SP_RAM_ARB_STATS_EN
        for (int k = 0; k < N; k++) check_eq("stall_cnt", stall_cnt[k], m_stall[k]);
        for (int k = 0; k < N; k++) begin
            if (stats_clr) m_stall[k] = 0;
            else if (req[k] && !eg[k] && m_stall[k] != 32'hFFFF_FFFF) m_stall[k]++;
        end
`endif
        if (w >= 0) begin
            r.onehot  = eg;
            r.is_read = !we[w];
            r.data    = exp_mem[addr[w]];
            sb.push_back(r);
            if (we[w]) exp_mem[addr[w]] = merge(exp_mem[addr[w]], wdata[w], be[w]);
            m_ptr = (w + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        addr[p]  = a;
        we[p]    = w;
        be[p]    = b;
        wdata[p] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) exp_mem[i] = '0;
`ifdef SP_RAM_ARB_STATS_EN
        for (int k = 0; k < N; k++) m_stall[k] = 0;
`endif
        m_ptr = 0;
        rst   = 1'b1;
        req   = 2'b11;
        addr  = '0;
        we    = '0;
        be    = '0;
        wdata = '0;
        #3;
        check_eq("reset_gnt", gnt, '0);
        check_eq("reset_rvalid", rvalid, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention from reset: 01,10,01,10
        req = 2'b11;
        for (int i = 0; i < 4; i++) step();
        req = 2'b00;
        step();

        // Data path: port1 partial write, then port0 reads it back
        req = 2'b10;
        set_port(1, 8'd5, 1'b1, 4'b0101, 32'hDEAD_BEEF);
        step();
        req = 2'b01;
        set_port(0, 8'd5, 1'b0, 4'b1111, 32'h0);
        step();
        req = 2'b00;
        #3;
        check_eq("rdata_0x00AD00EF", rdata, 32'h00AD_00EF);
        check_eq("rvalid_port0", rvalid, 2'b01);
        #(-0);
        @(posedge clk);
        #1;
        void'(sb.pop_front());

        // Solo port: granted every cycle, pointer ends at 1
        req = 2'b01;
        for (int i = 0; i < 3; i++) step();
        req = 2'b11;
        step();
        req = 2'b00;
        step();

        // Random traffic over a small address window
        for (int i = 0; i < 30; i++) begin
            req = N'($urandom);
            for (int p = 0; p < N; p++)
                set_port(p, AW'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), $urandom);
            step();
        end
        req = 2'b00;
        step();

        // Reset in the cycle of a grant
        we  = '0;
        req = 2'b01;
        step();
        req = 2'b11;
        #2;
        check_eq("pre_reset_gnt", gnt, rr_model(req, m_ptr));
        rst = 1'b1;
        #1;
        check_eq("reset_async_gnt", gnt, '0);
        check_eq("reset_async_rvalid", rvalid, '0);
        @(posedge clk);
        #1;
        check_eq("reset_no_rvalid", rvalid, '0);
        rst   = 1'b0;
        m_ptr = 0;
        sb.delete();
`ifdef SP_RAM_ARB_STATS_EN
        for (int k = 0; k < N; k++) m_stall[k] = 0;
`endif
        step();
        req = 2'b00;
        step();

`ifdef SP_RAM_ARB_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        req = 2'b11;
        for (int i = 0; i < 6; i++) step();
        req = 2'b00;
        #3;
        check_eq("stall_p0_3", stall_cnt[0], 32'd3);
        check_eq("stall_p1_3", stall_cnt[1], 32'd3);
        @(posedge clk);
        #1;
        void'(sb.pop_front());
        for (int k = 0; k < N; k++) m_stall[k] = 3;
        req = 2'b11;
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        req = 2'b00;
        #3;
        check_eq("stall_clr_p0", stall_cnt[0], 32'd0);
        check_eq("stall_clr_p1", stall_cnt[1], 32'd0);
        @(posedge clk);
        #1;
        void'(sb.pop_front());
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
